// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the write-back port arbiter.
package wb_arbiter_pkg;

   // Arbiter ownership states; encodings match the legacy IDLE/OWN0/OWN1 defines.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_e;

   localparam int unsigned WB_DATA_W            = 16;
   localparam int unsigned WB_ADDR_W            = 3;
   localparam int unsigned WB_MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/mux_2x1_16bit.sv
// 16-bit 2:1 multiplexer (S = 0 selects I0).
module mux_2x1_16bit (
   input  logic [15:0] I0,
   input  logic [15:0] I1,
   input  logic        S,
   output logic [15:0] O
);

   assign O = S ? I1 : I0;

endmodule

// File: rtl/mux_2x1_1bit.sv
// Single-bit 2:1 multiplexer (S = 0 selects I0).
module mux_2x1_1bit (
   input  logic I0,
   input  logic I1,
   input  logic S,
   output logic O
);

   assign O = S ? I1 : I0;

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the register-file write-back port between the
// ALU (requester 0) and memory load data (requester 1), with bounded bursts.
// Only DATA_W = 16 is supported (fixed-width data mux).
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W    = WB_DATA_W,
   parameter int unsigned ADDR_W    = WB_ADDR_W,
   parameter int unsigned MAX_BURST = WB_MAX_BURST_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [ADDR_W-1:0] req0_addr,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   input  logic [ADDR_W-1:0] req1_addr,
   output logic              req1_ready,
   output logic              wb_en,
   output logic [DATA_W-1:0] wb_data,
   output logic [ADDR_W-1:0] wb_addr,
   output logic              wb_src
);

   localparam int unsigned     CNT_W      = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W:0]  BURST_LAST = (CNT_W + 1)'(MAX_BURST);

   arb_state_e        state_q, state_d;
   logic              pri_q, pri_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wb_en_q, wb_en_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic              wb_src_q, wb_src_d;

   logic              own0, own1;
   logic              xfer0, xfer1, xfer;
   logic              owner_valid, other_valid;
   logic              last_beat;
   logic [CNT_W:0]    cnt_inc;
   logic [DATA_W-1:0] data_sel;
   logic [ADDR_W-1:0] addr_sel;

   // Ready depends only on registered state plus stall/rst: no valid->ready path.
   always_comb begin
      own0        = (state_q == ST_OWN0);
      own1        = (state_q == ST_OWN1);
      req0_ready  = own0 && !stall && !rst;
      req1_ready  = own1 && !stall && !rst;
      xfer0       = req0_valid && req0_ready;
      xfer1       = req1_valid && req1_ready;
      xfer        = xfer0 || xfer1;
      owner_valid = own1 ? req1_valid : req0_valid;
      other_valid = own1 ? req0_valid : req1_valid;
      cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
      last_beat   = (cnt_inc == BURST_LAST);
   end

   // Data select follows the current owner; only used when a beat transfers.
   mux_2x1_16bit u_data_mux (
      .I0 (req0_data),
      .I1 (req1_data),
      .S  (own1),
      .O  (data_sel)
   );

   for (genvar i = 0; i < ADDR_W; i++) begin : g_addr_mux
      mux_2x1_1bit u_addr_mux (
         .I0 (req0_addr[i]),
         .I1 (req1_addr[i]),
         .S  (own1),
         .O  (addr_sel[i])
      );
   end

   // Next ownership, burst count and tie priority; everything holds while stalled.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pri_d   = pri_q;
      if (!stall) begin
         unique case (state_q)
            ST_IDLE: begin
               if (req0_valid && req1_valid) begin
                  state_d = pri_q ? ST_OWN1 : ST_OWN0;
               end else if (req0_valid) begin
                  state_d = ST_OWN0;
               end else if (req1_valid) begin
                  state_d = ST_OWN1;
               end
            end
            ST_OWN0, ST_OWN1: begin
               // Both owner states share one branch: "other" is the non-owning side.
               if (owner_valid) begin
                  if (last_beat) begin
                     cnt_d = '0;
                     if (other_valid) begin
                        state_d = own1 ? ST_OWN0 : ST_OWN1;
                        pri_d   = own0;
                     end
                  end else begin
                     cnt_d = cnt_inc[CNT_W-1:0];
                  end
               end else begin
                  cnt_d   = '0;
                  pri_d   = own0;
                  state_d = other_valid ? (own1 ? ST_OWN0 : ST_OWN1) : ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Write-back beat capture: strobe for one cycle per transfer, hold data otherwise.
   always_comb begin
      wb_en_d   = xfer;
      wb_data_d = wb_data_q;
      wb_addr_d = wb_addr_q;
      wb_src_d  = wb_src_q;
      if (xfer) begin
         wb_data_d = data_sel;
         wb_addr_d = addr_sel;
         wb_src_d  = xfer1;
      end
   end

   // State and write-back registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pri_q     <= 1'b0;
         wb_en_q   <= 1'b0;
         wb_data_q <= '0;
         wb_addr_q <= '0;
         wb_src_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pri_q     <= pri_d;
         wb_en_q   <= wb_en_d;
         wb_data_q <= wb_data_d;
         wb_addr_q <= wb_addr_d;
         wb_src_q  <= wb_src_d;
      end
   end

   assign wb_en   = wb_en_q;
   assign wb_data = wb_data_q;
   assign wb_addr = wb_addr_q;
   assign wb_src  = wb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_wb_arbiter;

   localparam int MB = 4;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        req0_valid, req1_valid;
   logic [15:0] req0_data, req1_data;
   logic [2:0]  req0_addr, req1_addr;
   logic        req0_ready, req1_ready;
   logic        wb_en;
   logic [15:0] wb_data;
   logic [2:0]  wb_addr;
   logic        wb_src;

   wb_arbiter #(.DATA_W(16), .ADDR_W(3), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_addr  (req0_addr),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_addr  (req1_addr),
      .req1_ready (req1_ready),
      .wb_en      (wb_en),
      .wb_data    (wb_data),
      .wb_addr    (wb_addr),
      .wb_src     (wb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Behavioural model: who owns the port, beats taken in this turn, who wins a tie.
   int          m_owner;   // -1 = nobody
   int          m_taken;
   int          m_pref;
   logic        m_en;
   logic [15:0] m_data;
   logic [2:0]  m_addr;
   logic        m_src;
   bit          model_ok = 1'b0;

   always @(posedge clk) begin : model
      logic        v [2];
      logic [15:0] d [2];
      logic [2:0]  a [2];
      int          other;
      v[0] = req0_valid; v[1] = req1_valid;
      d[0] = req0_data;  d[1] = req1_data;
      a[0] = req0_addr;  a[1] = req1_addr;
      if (rst) begin
         m_owner = -1; m_taken = 0; m_pref = 0;
         m_en = 1'b0; m_data = '0; m_addr = '0; m_src = 1'b0;
         model_ok = 1'b1;
      end else begin
         m_en = 1'b0;
         if (!stall) begin
            if (m_owner < 0) begin
               if (v[0] && v[1]) m_owner = m_pref;
               else if (v[0])    m_owner = 0;
               else if (v[1])    m_owner = 1;
            end else begin
               other = 1 - m_owner;
               if (v[m_owner]) begin
                  m_en   = 1'b1;
                  m_data = d[m_owner];
                  m_addr = a[m_owner];
                  m_src  = (m_owner == 1);
                  m_taken++;
                  if (m_taken == MB) begin
                     m_taken = 0;
                     if (v[other]) begin
                        m_owner = other;
                        m_pref  = other;
                     end
                  end
               end else begin
                  m_taken = 0;
                  m_pref  = other;
                  m_owner = v[other] ? other : -1;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, plus a starvation bound per requester.
   int wcnt [2] = '{0, 0};

   always @(negedge clk) begin : compare
      logic exp_r0, exp_r1;
      logic vv [2];
      logic rr [2];
      if (model_ok) begin
         exp_r0 = (m_owner == 0) && !stall && !rst;
         exp_r1 = (m_owner == 1) && !stall && !rst;
         chk("req0_ready", req0_ready, exp_r0);
         chk("req1_ready", req1_ready, exp_r1);
         chk("wb_en",      wb_en,      m_en);
         chk("wb_data",    wb_data,    m_data);
         chk("wb_addr",    wb_addr,    m_addr);
         chk("wb_src",     wb_src,     m_src);
         vv[0] = req0_valid; vv[1] = req1_valid;
         rr[0] = req0_ready; rr[1] = req1_ready;
         for (int i = 0; i < 2; i++) begin
            if (rst || !vv[i]) begin
               wcnt[i] = 0;
            end else if (!stall) begin
               if (rr[i]) begin
                  if (wcnt[i] > 0) chk("fair_wait_bound", (wcnt[i] <= MB + 1), 1);
                  wcnt[i] = 0;
               end else begin
                  wcnt[i]++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      bit exp_src [9];
      bit found;
      exp_src = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      // Reset held with both requesters valid.
      rst = 1'b1; stall = 1'b0;
      req0_valid = 1'b1; req0_data = 16'h1234; req0_addr = 3'd1;
      req1_valid = 1'b1; req1_data = 16'h5678; req1_addr = 3'd2;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_ready0",  req0_ready, 0);
         chk("rst_ready1",  req1_ready, 0);
         chk("rst_wb_en",   wb_en,      0);
         chk("rst_wb_data", wb_data,    16'h0000);
      end

      // Single requester from IDLE.
      tick();
      rst = 1'b0;
      req0_valid = 1'b1; req0_data = 16'hABCD; req0_addr = 3'd5;
      req1_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("single_ready0", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("single_wb_en",   wb_en,   1);
      chk("single_wb_data", wb_data, 16'hABCD);
      chk("single_wb_addr", wb_addr, 3'd5);
      chk("single_wb_src",  wb_src,  0);

      // Contention with MAX_BURST = 4 after a fresh reset (pri = 0).
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0_valid = 1'b1; req0_data = 16'h1111; req0_addr = 3'd1;
      req1_valid = 1'b1; req1_data = 16'h0088; req1_addr = 3'd2;
      tick();
      for (int i = 0; i < 9; i++) begin
         tick();
         @(negedge clk);
         chk("contend_wb_en",   wb_en,  1);
         chk("contend_wb_src",  wb_src, exp_src[i]);
         chk("contend_wb_data", wb_data, exp_src[i] ? 16'h0088 : 16'h1111);
      end

      // Reset during an OWN1 burst: re-arbitration favours req0.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         @(negedge clk);
         if (req1_ready) found = 1'b1;
      end
      chk("midrst_reach_own1", found, 1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready0_in_rst", req0_ready, 0);
      chk("midrst_ready1_in_rst", req1_ready, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_idle_wb_en", wb_en, 0);
      tick();
      @(negedge clk);
      chk("midrst_ready0", req0_ready, 1);
      chk("midrst_ready1", req1_ready, 0);
      tick();
      @(negedge clk);
      chk("midrst_wb_en",   wb_en,   1);
      chk("midrst_wb_src",  wb_src,  0);
      chk("midrst_wb_data", wb_data, 16'h1111);

      // Randomized traffic with stalls and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst        = ($urandom_range(0, 99) < 2);
         stall      = ($urandom_range(0, 99) < 10);
         req0_valid = ($urandom_range(0, 99) < 70);
         req1_valid = ($urandom_range(0, 99) < 70);
         req0_data  = 16'($urandom);
         req1_data  = 16'($urandom);
         req0_addr  = 3'($urandom_range(0, 7));
         req1_addr  = 3'($urandom_range(0, 7));
      end
      tick();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
